// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
//  mc_ctrl_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I.
//  Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic [6:0]        opcode,
   input  logic              br_taken,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   output logic              imem_req,
   output logic              ir_wr,
   output logic              pc_wr,
   output logic              pc_sel,
   output logic              sel_A,
   output logic              sel_B,
   output logic              reg_wr,
   output logic              rd_en,
   output logic              wr_en,
   output logic [1:0]        wb_sel,
   output logic              halted,
   output logic              trap,
   output logic [1:0]        trap_cause,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [6:0] opcode_q, opcode_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] cause_q, cause_d;
   logic       waiting;

   function automatic logic f_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LD, OP_ST, OP_BR,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: f_legal = 1'b1;
         default:                           f_legal = 1'b0;
      endcase
   endfunction

   logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
   assign is_r     = (opcode_q == OP_R);
   assign is_i     = (opcode_q == OP_I);
   assign is_ld    = (opcode_q == OP_LD);
   assign is_st    = (opcode_q == OP_ST);
   assign is_br    = (opcode_q == OP_BR);
   assign is_jal   = (opcode_q == OP_JAL);
   assign is_jalr  = (opcode_q == OP_JALR);
   assign is_lui   = (opcode_q == OP_LUI);
   assign is_auipc = (opcode_q == OP_AUIPC);

   // Selects decode only legal opcodes so the reset value (opcode_q=0) drives all zeros.
   assign sel_A  = is_r | is_i | is_ld | is_st | is_jalr;
   assign sel_B  = is_i | is_ld | is_st | is_jal | is_jalr | is_lui | is_auipc;
   assign wb_sel = (is_jal | is_jalr) ? 2'b00 :
                   is_ld              ? 2'b10 :
                   (is_r | is_i | is_st | is_br | is_lui | is_auipc) ? 2'b01 : 2'b00;

   assign trap       = (state_q == S_TRAP);
   assign trap_cause = cause_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         wait_q   <= '0;
         cause_q  <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      wait_d   = '0;
      cause_d  = cause_q;
      imem_req = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      pc_sel   = 1'b0;
      reg_wr   = 1'b0;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      halted   = 1'b0;
      waiting  = 1'b0;

      case (state_q)
         S_FETCH: begin
            // A nonzero wait count means a fetch is already in flight; halt no longer applies.
            if (halt && (wait_q == '0)) begin
               halted = 1'b1;
            end else begin
               imem_req = 1'b1;
               waiting  = ~imem_ready;
               if (imem_ready) begin
                  ir_wr   = 1'b1;
                  state_d = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            opcode_d = opcode;
            if (f_legal(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_EXEC: begin
            if (is_br) begin
               pc_wr   = 1'b1;
               pc_sel  = br_taken;
               state_d = S_FETCH;
            end else if (is_ld || is_st) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            rd_en   = is_ld;
            wr_en   = is_st;
            waiting = ~dmem_ready;
            if (dmem_ready) begin
               if (is_ld) begin
                  state_d = S_WB;
               end else begin
                  pc_wr   = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            reg_wr  = 1'b1;
            pc_wr   = 1'b1;
            pc_sel  = is_jal | is_jalr;
            state_d = S_FETCH;
         end
         S_TRAP: ;
         default: state_d = S_FETCH;
      endcase

      if (waiting) begin
         if (wait_q == TIMEOUT_LAST) begin
            state_d = S_TRAP;
            cause_d = (state_q == S_FETCH) ? 2'b10 : 2'b11;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end

      // Strobes drop as soon as reset rises, not at the next edge.
      if (reset) begin
         imem_req = 1'b0;
         ir_wr    = 1'b0;
         pc_wr    = 1'b0;
         pc_sel   = 1'b0;
         reg_wr   = 1'b0;
         rd_en    = 1'b0;
         wr_en    = 1'b0;
         halted   = 1'b0;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [PERF_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if ((state_q != S_TRAP) && !halted)
            cycle_q <= cycle_q + 1'b1;
         if (pc_wr)
            instret_q <= instret_q + 1'b1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
//  tb_mc_ctrl_fsm : directed self-checking bench for mc_ctrl_fsm.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        halt = 1'b0;
   logic [6:0]  opcode = '0;
   logic        br_taken = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, ir_wr, pc_wr, pc_sel, sel_A, sel_B, reg_wr;
   logic        rd_en, wr_en, halted, trap;
   logic [1:0]  wb_sel, trap_cause;
   logic [31:0] cycle_cnt, instret_cnt;

   mc_ctrl_fsm #(.MEM_TIMEOUT(16), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .halt(halt), .opcode(opcode),
      .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
      .sel_A(sel_A), .sel_B(sel_B), .reg_wr(reg_wr), .rd_en(rd_en),
      .wr_en(wr_en), .wb_sel(wb_sel), .halted(halted), .trap(trap),
      .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // {imem_req, ir_wr, pc_wr, pc_sel, reg_wr, rd_en, wr_en, halted, trap}
   logic [8:0] strb;
   assign strb = {imem_req, ir_wr, pc_wr, pc_sel, reg_wr, rd_en, wr_en, halted, trap};

   localparam logic [8:0] IDLE    = 9'b000000000;
   localparam logic [8:0] F_RDY   = 9'b110000000;
   localparam logic [8:0] F_WAIT  = 9'b100000000;
   localparam logic [8:0] WB_S    = 9'b001010000;
   localparam logic [8:0] BR_T    = 9'b001100000;
   localparam logic [8:0] BR_N    = 9'b001000000;
   localparam logic [8:0] LD_M    = 9'b000001000;
   localparam logic [8:0] ST_M    = 9'b000000100;
   localparam logic [8:0] ST_DONE = 9'b001000100;
   localparam logic [8:0] HLT     = 9'b000000010;
   localparam logic [8:0] TRP     = 9'b000000001;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

`ifdef CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pexp(input int v);
      return PERF ? 32'(v) : 32'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_s(input string tag, input logic [8:0] e);
      #1;
      check(tag, 32'(strb), 32'(e));
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      halt       = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      br_taken   = 1'b0;
      opcode     = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #1 reset = 1'b1;
      #2;
      check("rst_strb", 32'(strb), 32'(IDLE));
      check("rst_sel", 32'({sel_A, sel_B, wb_sel}), 32'd0);
      check("rst_cause", 32'(trap_cause), 32'd0);
      check("rst_cycle", cycle_cnt, 32'd0);

      // R-type, zero-wait
      do_reset();
      opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1;
      exp_s("r_fetch", F_RDY);
      step(); exp_s("r_decode", IDLE);
      step(); exp_s("r_exec", IDLE);
      check("r_sel", 32'({sel_A, sel_B, wb_sel}), 32'b1001);
      step(); exp_s("r_wb", WB_S);
      check("r_wbsel", 32'(wb_sel), 32'b01);
      step(); imem_ready = 1'b0; exp_s("r_next", F_WAIT);
      check("r_instret", instret_cnt, pexp(1));
      check("r_cycles", cycle_cnt, pexp(4));

      // Load with three data wait states
      do_reset();
      opcode = OP_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
      exp_s("ld_fetch", F_RDY);
      step(); exp_s("ld_decode", IDLE);
      step(); exp_s("ld_exec", IDLE);
      for (int i = 0; i < 3; i++) begin
         step(); exp_s("ld_mem_wait", LD_M);
      end
      step(); dmem_ready = 1'b1; exp_s("ld_mem_done", LD_M);
      step(); exp_s("ld_wb", WB_S);
      check("ld_wbsel", 32'(wb_sel), 32'b10);
      step();
      check("ld_cycles", cycle_cnt, pexp(8));
      check("ld_instret", instret_cnt, pexp(1));

      // Branch taken / not taken
      do_reset();
      opcode = OP_BR; imem_ready = 1'b1; br_taken = 1'b1;
      exp_s("brt_fetch", F_RDY);
      step(); exp_s("brt_decode", IDLE);
      step(); exp_s("brt_exec", BR_T);
      check("brt_sel", 32'({sel_A, sel_B}), 32'b00);
      step(); exp_s("brt_next", F_RDY);
      check("brt_instret", instret_cnt, pexp(1));

      do_reset();
      opcode = OP_BR; imem_ready = 1'b1; br_taken = 1'b0;
      exp_s("brn_fetch", F_RDY);
      step(); exp_s("brn_decode", IDLE);
      step(); exp_s("brn_exec", BR_N);
      step(); exp_s("brn_next", F_RDY);

      // Store, zero-wait
      do_reset();
      opcode = OP_ST; imem_ready = 1'b1; dmem_ready = 1'b1;
      exp_s("st_fetch", F_RDY);
      step(); exp_s("st_decode", IDLE);
      step(); exp_s("st_exec", IDLE);
      step(); exp_s("st_mem", ST_DONE);
      step(); exp_s("st_next", F_RDY);
      check("st_instret", instret_cnt, pexp(1));

      // Reset asserted mid-MEM while wr_en is high
      do_reset();
      opcode = OP_ST; imem_ready = 1'b1; dmem_ready = 1'b0;
      exp_s("stw_fetch", F_RDY);
      step(); step(); step();
      exp_s("stw_mem", ST_M);
      #1 reset = 1'b1;
      #1;
      check("stw_rst_strb", 32'(strb), 32'(IDLE));
      do_reset();
      exp_s("stw_rst_fetch", F_WAIT);

      // Illegal opcode
      do_reset();
      opcode = OP_BAD; imem_ready = 1'b1;
      exp_s("ill_fetch", F_RDY);
      step(); exp_s("ill_decode", IDLE);
      step(); exp_s("ill_trap", TRP);
      check("ill_cause", 32'(trap_cause), 32'b01);
      halt = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(); exp_s("ill_hold", TRP);
      end
      check("ill_cause_frozen", 32'(trap_cause), 32'b01);
      check("ill_cycles", cycle_cnt, pexp(2));
      check("ill_instret", instret_cnt, 32'd0);

      // Instruction fetch timeout
      do_reset();
      opcode = OP_R; imem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         exp_s("ito_wait", F_WAIT);
      end
      step(); exp_s("ito_trap", TRP);
      check("ito_cause", 32'(trap_cause), 32'b10);

      // Ready arriving on the 16th waiting cycle still wins
      do_reset();
      opcode = OP_R; imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) step();
         exp_s("ilate_wait", F_WAIT);
      end
      step(); imem_ready = 1'b1; exp_s("ilate_fetch", F_RDY);
      step(); exp_s("ilate_decode", IDLE);
      step(); exp_s("ilate_exec", IDLE);

      // Data memory timeout
      do_reset();
      opcode = OP_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
      exp_s("dto_fetch", F_RDY);
      step(); step();
      for (int i = 0; i < 16; i++) begin
         step(); exp_s("dto_wait", LD_M);
      end
      step(); exp_s("dto_trap", TRP);
      check("dto_cause", 32'(trap_cause), 32'b11);

      // Halt: idle fetch parks; a waited fetch completes first
      do_reset();
      halt = 1'b1; imem_ready = 1'b0; opcode = OP_R;
      exp_s("hlt_idle", HLT);
      step(); exp_s("hlt_idle2", HLT);
      check("hlt_cycles", cycle_cnt, 32'd0);
      halt = 1'b0; exp_s("hlt_start", F_WAIT);
      step(); halt = 1'b1; exp_s("hlt_inflight", F_WAIT);
      step(); imem_ready = 1'b1; exp_s("hlt_done", F_RDY);
      step(); exp_s("hlt_decode", IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
